// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: FSM state encoding, S-memory depth, default key
// length and the cyclic key-byte selector used by the key schedule.
package arc4_pkg;

  localparam int S_DEPTH       = 256;
  localparam int KEY_BYTES     = 3;
  localparam int MAX_KEY_BYTES = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_I    = 3'd1,
    LATCH_I = 3'd2,
    RD_J    = 3'd3,
    LATCH_J = 3'd4,
    WR_I    = 3'd5,
    WR_J    = 3'd6
  } ksa_state_e;

  // Byte (i mod nbytes) of an MSB-first key held right-aligned in key_v.
  function automatic logic [7:0] key_byte(
    input logic [8*MAX_KEY_BYTES-1:0] key_v,
    input int                         nbytes,
    input logic [7:0]                 i
  );
    int idx;
    idx = int'(i) % nbytes;
    return 8'(key_v >> (8 * (nbytes - 1 - idx)));
  endfunction

endpackage

// File: rtl/ksa_if.sv
// Start/ready handshake, key and S-memory port of the ARC4 key scheduler.
interface ksa_if #(
  parameter int KEY_BYTES = arc4_pkg::KEY_BYTES
);

  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;
  logic [7:0]             addr;
  logic [7:0]             rddata;
  logic [7:0]             wrdata;
  logic                   wren;

  modport master (
    input  en,
    input  key,
    input  rddata,
    output rdy,
    output addr,
    output wrdata,
    output wren
  );

  modport slave (
    output en,
    output key,
    output rddata,
    input  rdy,
    input  addr,
    input  wrdata,
    input  wren
  );

endinterface

// File: rtl/ksa.sv
// ARC4 key schedule over an externally held, pre-initialised 256-byte S memory
// with one-cycle read latency; six cycles per index, 1536 cycles per run.
module ksa
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = arc4_pkg::KEY_BYTES
) (
  input  logic   clk,
  input  logic   rst_n,
  ksa_if.master  bus
);

  ksa_state_e             state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [7:0]             si_q, sj_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic                   ld_key, ld_si, ld_sj;

  logic [8*MAX_KEY_BYTES-1:0] key_ext;
  logic [7:0]                 kb;

  assign key_ext = (8*MAX_KEY_BYTES)'(key_q);
  assign kb      = key_byte(key_ext, KEY_BYTES, i_q);

  // Control registers: state and the two indices are cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // Data registers carry no reset; outputs never expose them outside WR_I/WR_J.
  always_ff @(posedge clk) begin
    if (ld_key) key_q <= bus.key;
    if (ld_si)  si_q  <= bus.rddata;
    if (ld_sj)  sj_q  <= bus.rddata;
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    ld_key     = 1'b0;
    ld_si      = 1'b0;
    ld_sj      = 1'b0;
    bus.rdy    = 1'b0;
    bus.wren   = 1'b0;
    bus.addr   = '0;
    bus.wrdata = '0;
    unique case (state_q)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) begin
          ld_key  = 1'b1;
          i_d     = '0;
          j_d     = '0;
          state_d = RD_I;
        end
      end
      RD_I: begin
        bus.addr = i_q;
        state_d  = LATCH_I;
      end
      LATCH_I: begin
        bus.addr = i_q;
        ld_si    = 1'b1;
        j_d      = j_q + bus.rddata + kb;
        state_d  = RD_J;
      end
      RD_J: begin
        bus.addr = j_q;
        state_d  = LATCH_J;
      end
      LATCH_J: begin
        bus.addr = j_q;
        ld_sj    = 1'b1;
        state_d  = WR_I;
      end
      WR_I: begin
        bus.addr   = i_q;
        bus.wrdata = sj_q;
        bus.wren   = 1'b1;
        state_d    = WR_J;
      end
      WR_J: begin
        // When i == j this second write restores the original S[i].
        bus.addr   = j_q;
        bus.wrdata = si_q;
        bus.wren   = 1'b1;
        if (i_q == 8'(S_DEPTH - 1)) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          state_d = RD_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
